// File: rtl/milano_pkg.sv
// Shared types for the instruction prefetch path: the queued {pc, instr} entry
// and the default address/data widths it is built from.
package milano_pkg;

   localparam int FETCH_ADDR_W = 32;
   localparam int FETCH_DATA_W = 32;
   localparam int PC_INCR      = FETCH_DATA_W / 8;

   typedef struct packed {
      logic [FETCH_ADDR_W-1:0] pc;
      logic [FETCH_DATA_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// Small synchronous FIFO of fetch entries with flush; head is read straight from
// the register array so a word pushed in one cycle is visible the next.
module prefetch_fifo
   import milano_pkg::*;
#(
   parameter int  DEPTH   = 4,
   parameter type entry_t = fetch_entry_t,
   localparam int PTR_W   = $clog2(DEPTH),
   localparam int CNT_W   = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  entry_t           wdata_i,
   output entry_t           rdata_o,
   output logic [CNT_W-1:0] count_o,
   output logic             full_o,
   output logic             empty_o
);

   entry_t             mem_reg [DEPTH];
   logic [PTR_W-1:0]   rd_ptr_reg, wr_ptr_reg;
   logic [CNT_W-1:0]   count_reg, count_next;
   logic               do_push, do_pop;

   assign full_o  = (count_reg == CNT_W'(DEPTH));
   assign empty_o = (count_reg == '0);
   assign count_o = count_reg;
   assign rdata_o = mem_reg[rd_ptr_reg];

   // A pop on empty is ignored, so an empty push+pop just fills one slot.
   assign do_push = push_i & (~full_o | pop_i);
   assign do_pop  = pop_i & ~empty_o;

   always_comb begin
      count_next = count_reg;
      if (do_push && !do_pop) begin
         count_next = count_reg + 1'b1;
      end else if (!do_push && do_pop) begin
         count_next = count_reg - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush_i) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         count_reg <= count_next;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push && !flush_i) begin
         mem_reg[wr_ptr_reg] <= wdata_i;
      end
   end

endmodule

// File: rtl/prefetch_buffer.sv
// Pipelined instruction prefetcher: credit-limited req/gnt issue, in-order
// response capture into a FIFO, and redirect handling that drops stale responses.
module prefetch_buffer
   import milano_pkg::*;
#(
   parameter int DEPTH           = 4,
   parameter int MAX_OUTSTANDING = 2,
   parameter int ADDR_W          = FETCH_ADDR_W,
   parameter int DATA_W          = FETCH_DATA_W
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [ADDR_W-1:0] boot_addr_i,
   input  logic              stall_from_ctrl_i,
   input  logic              jump_flag_i,
   input  logic [ADDR_W-1:0] jump_addr_i,
   input  logic              ctrl_jump_flag_i,
   input  logic [ADDR_W-1:0] ctrl_jump_addr_i,
   output logic              fetch_enable_o,
   output logic              instr_req_o,
   output logic [ADDR_W-1:0] instr_addr_o,
   input  logic              instr_gnt_i,
   input  logic              instr_rvalid_i,
   input  logic [DATA_W-1:0] instr_rdata_i,
   output logic              instr_valid_o,
   output logic [ADDR_W-1:0] instr_pc_o,
   output logic [DATA_W-1:0] instr_rdata_o,
   input  logic              instr_ready_i
);

   localparam int                CNT_W = $clog2(DEPTH + 1);
   localparam logic [ADDR_W-1:0] INCR  = ADDR_W'(DATA_W / 8);

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] instr;
   } entry_t;

   logic              fetch_en_reg;
   logic [ADDR_W-1:0] addr_reg, resp_pc_reg, target;
   logic [CNT_W-1:0]  outstanding_reg, outstanding_next;
   logic [CNT_W-1:0]  discard_reg, discard_next;
   logic [CNT_W-1:0]  fifo_count;
   logic [CNT_W:0]    credit_used;
   logic              fifo_full, fifo_empty;
   logic              handshake, redirect, resp_valid, drop, push, pop;
   entry_t            head, push_entry;

   assign redirect = fetch_en_reg & (ctrl_jump_flag_i | jump_flag_i);
   assign target   = ctrl_jump_flag_i ? ctrl_jump_addr_i : jump_addr_i;

   // Reserve a FIFO slot for every in-flight word so a response always has room.
   assign credit_used = {1'b0, outstanding_reg} + {1'b0, fifo_count};
   assign instr_req_o = fetch_en_reg & ~stall_from_ctrl_i
                      & (outstanding_reg < CNT_W'(MAX_OUTSTANDING))
                      & (credit_used < (CNT_W + 1)'(DEPTH));
   assign handshake   = instr_req_o & instr_gnt_i;

   assign resp_valid = instr_rvalid_i & (outstanding_reg != '0);
   assign drop       = resp_valid & (discard_reg != '0);
   assign push       = resp_valid & ~drop;
   assign pop        = instr_valid_o & instr_ready_i;

   always_comb begin
      outstanding_next = outstanding_reg;
      if (handshake && !resp_valid) begin
         outstanding_next = outstanding_reg + 1'b1;
      end else if (!handshake && resp_valid) begin
         outstanding_next = outstanding_reg - 1'b1;
      end
   end

   // On redirect every word still in flight afterwards belongs to the old stream.
   always_comb begin
      discard_next = discard_reg;
      if (redirect) begin
         discard_next = outstanding_next;
      end else if (drop) begin
         discard_next = discard_reg - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fetch_en_reg    <= 1'b0;
         addr_reg        <= boot_addr_i;
         resp_pc_reg     <= boot_addr_i;
         outstanding_reg <= '0;
         discard_reg     <= '0;
      end else begin
         outstanding_reg <= outstanding_next;
         discard_reg     <= discard_next;
         if (!fetch_en_reg) begin
            fetch_en_reg <= 1'b1;
            addr_reg     <= boot_addr_i;
            resp_pc_reg  <= boot_addr_i;
         end else if (redirect) begin
            addr_reg    <= target;
            resp_pc_reg <= target;
         end else begin
            if (handshake) addr_reg    <= addr_reg + INCR;
            if (push)      resp_pc_reg <= resp_pc_reg + INCR;
         end
      end
   end

   assign push_entry = '{pc: resp_pc_reg, instr: instr_rdata_i};

   prefetch_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (redirect),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (push_entry),
      .rdata_o (head),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign fetch_enable_o = fetch_en_reg;
   assign instr_addr_o   = addr_reg;
   assign instr_valid_o  = ~fifo_empty;
   assign instr_pc_o     = head.pc;
   assign instr_rdata_o  = head.instr;

   rvalid_without_request: assert property (@(posedge clk_i) disable iff (!rst_ni)
      instr_rvalid_i |-> (outstanding_reg != '0));
   push_into_full_fifo: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (push && !redirect) |-> (!fifo_full || pop));

endmodule

// File: tb/tb_prefetch_buffer.sv
// Bench for prefetch_buffer: a randomised instruction memory plus a stream-level
// model (expected next pc, restarting at each redirect target) checks every pop.
module tb_prefetch_buffer;

   localparam int DEPTH = 4;
   localparam int MAXO  = 2;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic [31:0] boot_addr = 32'h8000_0000;
   logic        stall = 1'b0;
   logic        jump_flag = 1'b0;
   logic [31:0] jump_addr = '0;
   logic        ctrl_jump_flag = 1'b0;
   logic [31:0] ctrl_jump_addr = '0;
   logic        fetch_enable;
   logic        instr_req;
   logic [31:0] instr_addr;
   logic        instr_gnt = 1'b0;
   logic        instr_rvalid = 1'b0;
   logic [31:0] instr_rdata = '0;
   logic        instr_valid;
   logic [31:0] instr_pc;
   logic [31:0] instr_rdata_out;
   logic        instr_ready = 1'b0;

   int          total = 0;
   int          bad = 0;
   int          gnt_prob = 100;
   int          rv_prob = 100;
   logic [31:0] pending[$];
   logic [31:0] popped[$];
   logic [31:0] exp_pc = 32'h8000_0000;
   int          pops = 0;
   int          cycle = 0;
   int          first_gnt = -1;
   int          first_valid = -1;
   logic        prev_wait = 1'b0;
   logic [31:0] prev_addr = '0;

   always #5 clk = ~clk;

   prefetch_buffer #(
      .DEPTH           (DEPTH),
      .MAX_OUTSTANDING (MAXO),
      .ADDR_W          (32),
      .DATA_W          (32)
   ) dut (
      .clk_i             (clk),
      .rst_ni            (rst_ni),
      .boot_addr_i       (boot_addr),
      .stall_from_ctrl_i (stall),
      .jump_flag_i       (jump_flag),
      .jump_addr_i       (jump_addr),
      .ctrl_jump_flag_i  (ctrl_jump_flag),
      .ctrl_jump_addr_i  (ctrl_jump_addr),
      .fetch_enable_o    (fetch_enable),
      .instr_req_o       (instr_req),
      .instr_addr_o      (instr_addr),
      .instr_gnt_i       (instr_gnt),
      .instr_rvalid_i    (instr_rvalid),
      .instr_rdata_i     (instr_rdata),
      .instr_valid_o     (instr_valid),
      .instr_pc_o        (instr_pc),
      .instr_rdata_o     (instr_rdata_out),
      .instr_ready_i     (instr_ready)
   );

   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_pop(input string tag, input int idx, input logic [31:0] exp);
      if (popped.size() > idx) check(tag, popped[idx], exp);
      else check({tag, "_missing"}, popped.size(), idx + 1);
   endtask

   task automatic wait_pops(input int target, input int budget, input string tag);
      int n = 0;
      while (pops < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      #3;
      check(tag, 32'(pops >= target), 1);
   endtask

   // Memory responder and stream monitor: drive at negedge+1, sample at negedge+2.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (!rst_ni) begin
            instr_gnt    = 1'b0;
            instr_rvalid = 1'b0;
         end else begin
            instr_gnt    = ($urandom_range(99) < gnt_prob);
            instr_rvalid = (pending.size() > 0) && ($urandom_range(99) < rv_prob);
            instr_rdata  = instr_rvalid ? memf(pending[0]) : $urandom;
         end
         #1;
         cycle++;
         if (!rst_ni) begin
            pending.delete();
            popped.delete();
            exp_pc      = boot_addr;
            prev_wait   = 1'b0;
            first_gnt   = -1;
            first_valid = -1;
         end else begin
            if (stall) check("stall_blocks_req", 32'(instr_req), 0);
            if (prev_wait && instr_req) check("addr_held", instr_addr, prev_addr);
            if (instr_valid && first_valid < 0) first_valid = cycle;
            if (instr_valid && instr_ready) begin
               check("pop_pc", instr_pc, exp_pc);
               check("pop_data", instr_rdata_out, memf(exp_pc));
               popped.push_back(instr_pc);
               pops++;
               exp_pc = exp_pc + 32'd4;
            end
            if (instr_rvalid) void'(pending.pop_front());
            if (instr_req && instr_gnt) begin
               pending.push_back(instr_addr);
               if (first_gnt < 0) first_gnt = cycle;
            end
            check("outstanding_le_max", 32'(pending.size() <= MAXO), 1);
            if (ctrl_jump_flag) exp_pc = ctrl_jump_addr;
            else if (jump_flag) exp_pc = jump_addr;
            prev_wait = instr_req && !instr_gnt && !(jump_flag || ctrl_jump_flag);
            prev_addr = instr_addr;
         end
      end
   end

   initial begin
      int base;
      int r;
      instr_ready = 1'b1;
      repeat (3) @(negedge clk);
      #3;
      check("rst_fetch_enable", 32'(fetch_enable), 0);
      check("rst_req", 32'(instr_req), 0);
      check("rst_addr", instr_addr, 32'h8000_0000);
      check("rst_valid", 32'(instr_valid), 0);
      @(negedge clk);
      rst_ni = 1'b1;
      #3;
      check("first_cycle_fetch_enable", 32'(fetch_enable), 0);
      check("first_cycle_req", 32'(instr_req), 0);
      @(negedge clk);
      #3;
      check("fetch_enable_after", 32'(fetch_enable), 1);

      // Boot sequence with immediate grant and next-cycle response.
      wait_pops(3, 40, "boot_timeout");
      check_pop("boot_pc0", 0, 32'h8000_0000);
      check_pop("boot_pc1", 1, 32'h8000_0004);
      check_pop("boot_pc2", 2, 32'h8000_0008);
      check("boot_latency", 32'(first_valid - first_gnt), 2);

      // Backpressure: decode stalls, FIFO fills to DEPTH and issue stops.
      @(negedge clk);
      instr_ready = 1'b0;
      repeat (10) @(negedge clk);
      #3;
      check("bp_req_low", 32'(instr_req), 0);
      check("bp_valid", 32'(instr_valid), 1);
      @(negedge clk);
      gnt_prob    = 0;
      instr_ready = 1'b1;
      base = pops;
      repeat (8) @(negedge clk);
      #3;
      check("bp_held_entries", 32'(pops - base), DEPTH);

      // Redirect with two requests in flight.
      @(negedge clk);
      gnt_prob = 100;
      rv_prob  = 0;
      repeat (4) @(negedge clk);
      #3;
      check("inflight_count", 32'(pending.size()), 2);
      check("inflight_req_low", 32'(instr_req), 0);
      @(negedge clk);
      jump_flag = 1'b1;
      jump_addr = 32'h0000_0100;
      @(negedge clk);
      jump_flag = 1'b0;
      rv_prob   = 100;
      base = popped.size();
      wait_pops(pops + 2, 40, "jump_timeout");
      check_pop("jump_pc0", base, 32'h0000_0100);
      check_pop("jump_pc1", base + 1, 32'h0000_0104);

      // ctrl and EX redirect in the same cycle: ctrl wins.
      @(negedge clk);
      ctrl_jump_flag = 1'b1;
      ctrl_jump_addr = 32'h0000_0200;
      jump_flag      = 1'b1;
      jump_addr      = 32'h0000_0300;
      @(negedge clk);
      ctrl_jump_flag = 1'b0;
      jump_flag      = 1'b0;
      base = popped.size();
      wait_pops(pops + 3, 40, "ctrl_timeout");
      check_pop("ctrl_pc0", base, 32'h0000_0200);
      check_pop("ctrl_pc2", base + 2, 32'h0000_0208);

      // Address wrap from the top of the address space, reset mid-transfer.
      @(negedge clk);
      rst_ni    = 1'b0;
      boot_addr = 32'hFFFF_FFFC;
      repeat (2) @(negedge clk);
      #3;
      check("rst2_valid", 32'(instr_valid), 0);
      check("rst2_addr", instr_addr, 32'hFFFF_FFFC);
      @(negedge clk);
      rst_ni = 1'b1;
      wait_pops(pops + 2, 40, "wrap_timeout");
      check_pop("wrap_pc0", 0, 32'hFFFF_FFFC);
      check_pop("wrap_pc1", 1, 32'h0000_0000);

      // Random stall, grant/response delays, decode backpressure and redirects.
      gnt_prob = 60;
      rv_prob  = 50;
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         stall       = ($urandom_range(99) < 20);
         instr_ready = ($urandom_range(99) < 70);
         r = int'($urandom_range(99));
         ctrl_jump_flag = (r < 2);
         jump_flag      = (r == 0) || (r >= 2 && r < 5);
         ctrl_jump_addr = $urandom & 32'hFFFF_FFFC;
         jump_addr      = $urandom & 32'hFFFF_FFFC;
      end
      @(negedge clk);
      stall          = 1'b0;
      ctrl_jump_flag = 1'b0;
      jump_flag      = 1'b0;
      instr_ready    = 1'b1;
      gnt_prob       = 100;
      rv_prob        = 100;
      wait_pops(pops + 6, 60, "random_drain_timeout");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "bench time limit reached");
   end

endmodule
